// File: rtl/shift_sched_if.sv
// Bus bundle between the requesters, the shift_sched scheduler and the shared parshift serializer.
// master = scheduler side, slave = requesters plus the serializer.
interface shift_sched_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned CHW = $clog2(NREQ);

    logic                    en;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         ack;
    logic                    sr_load;
    logic [WIDTH-1:0]        sr_din;
    logic                    sr_done;
    logic                    frame;
    logic [CHW-1:0]          chan;
    logic                    err;

    modport master (
        input  en, req, req_data, sr_done,
        output ack, sr_load, sr_din, frame, chan, err
    );

    modport slave (
        output en, req, req_data, sr_done,
        input  ack, sr_load, sr_din, frame, chan, err
    );
endinterface

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one parshift serializer among NREQ requesters, MSB-first, GAP idle bits.
// Optional macro SHIFT_SCHED_DONE_CHECK_EN: checks parshift sr_done timing and raises a sticky err.
module shift_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic          clk,
    input  logic          rst,
    shift_sched_if.master bus
);
    localparam int unsigned CHW = $clog2(NREQ);
    localparam int unsigned BCW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
    localparam int unsigned GCW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 2);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_e;

    state_e           state_q, state_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [GCW-1:0]   gapcnt_q, gapcnt_d;
    logic [CHW-1:0]   last_q, last_d;
    logic [CHW-1:0]   chan_q, chan_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [WIDTH-1:0] sr_din_q, sr_din_d;
    logic             sr_load_q, sr_load_d;
    logic             frame_q, frame_d;

    logic [WIDTH-1:0] words_c [NREQ];
    logic             grant_c;
    logic [CHW-1:0]   win_c;
    logic             last_shift_c;
    logic             ap_c;

    for (genvar g = 0; g < NREQ; g++) begin : g_word
        assign words_c[g] = bus.req_data[g*WIDTH +: WIDTH];
    end

    // First set request at or after last+1, wrapping; lower offsets override higher ones.
    always_comb begin : arb
        logic [CHW-1:0] sel;
        grant_c = 1'b0;
        win_c   = last_q;
        sel     = last_q;
        for (int k = int'(NREQ); k >= 1; k--) begin
            sel = CHW'((int'(last_q) + k) % int'(NREQ));
            if (bus.req[sel]) begin
                grant_c = 1'b1;
                win_c   = sel;
            end
        end
    end

    assign last_shift_c = (state_q == S_SHIFT) && (bitcnt_q == BIT_LAST);
    assign ap_c = (state_q == S_IDLE)
               || ((state_q == S_GAP) && (gapcnt_q == GAP_LAST))
               || ((GAP == 0) && last_shift_c);

    always_comb begin : fsm_next
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        last_d   = last_q;
        chan_d   = chan_q;
        ack_d    = '0;
        sr_din_d = '0;

        case (state_q)
            S_LOAD: begin
                state_d  = S_SHIFT;
                bitcnt_d = '0;
            end
            S_SHIFT: begin
                if (!last_shift_c) begin
                    bitcnt_d = bitcnt_q + BCW'(1);
                end else if (GAP != 0) begin
                    state_d  = S_GAP;
                    gapcnt_d = '0;
                end
            end
            S_GAP: begin
                if (gapcnt_q != GAP_LAST) gapcnt_d = gapcnt_q + GCW'(1);
            end
            default: ;
        endcase

        // Arbitration point overrides the sequencing above.
        if (ap_c) begin
            if (bus.en && grant_c) begin
                state_d  = S_LOAD;
                last_d   = win_c;
                chan_d   = win_c;
                ack_d    = NREQ'(1) << win_c;
                sr_din_d = words_c[win_c];
            end else begin
                state_d  = S_IDLE;
            end
        end

        sr_load_d = (state_d != S_SHIFT);
        frame_d   = (state_d == S_SHIFT) || last_shift_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            gapcnt_q  <= '0;
            last_q    <= CHW'(NREQ - 1);
            chan_q    <= '0;
            ack_q     <= '0;
            sr_din_q  <= '0;
            sr_load_q <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            gapcnt_q  <= gapcnt_d;
            last_q    <= last_d;
            chan_q    <= chan_d;
            ack_q     <= ack_d;
            sr_din_q  <= sr_din_d;
            sr_load_q <= sr_load_d;
            frame_q   <= frame_d;
        end
    end

`ifdef SHIFT_SCHED_DONE_CHECK_EN
    logic done_hi_q;
    logic err_q, err_d;

    // done must be low while loading/shifting and high in the cycle after the last shift.
    always_comb begin : done_chk
        err_d = err_q;
        if (done_hi_q) begin
            if (!bus.sr_done) err_d = 1'b1;
        end else if (((state_q == S_LOAD) || (state_q == S_SHIFT)) && bus.sr_done) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_hi_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_hi_q <= last_shift_c;
            err_q     <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic done_unused;
    assign done_unused = bus.sr_done;
    assign bus.err     = 1'b0;
`endif

    assign bus.ack     = ack_q;
    assign bus.sr_load = sr_load_q;
    assign bus.sr_din  = sr_din_q;
    assign bus.frame   = frame_q;
    assign bus.chan    = chan_q;
endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: table vectors, hand sequences and a frame-level reference model with a parshift stand-in.
module tb_shift_sched;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int GAP   = 1;
    localparam int BW    = $clog2(WIDTH);
    localparam int CW    = $clog2(NREQ);

    typedef struct {
        logic             en;
        logic [NREQ-1:0]  req;
        logic [NREQ-1:0]  ack;
        logic             load;
        logic [WIDTH-1:0] din;
        logic             frame;
        logic             sout;
        logic [CW-1:0]    chan;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_kill = 1'b0;
    always #5 clk = ~clk;

    shift_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus1 ();
    shift_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus0 ();

    shift_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    shift_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP(0)) dut_g0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // parshift stand-ins: load din or shift left, sout = MSB, done after WIDTH-1 shifts
    logic [WIDTH-1:0] sh1, sh0;
    logic [3:0]       cnt1, cnt0;

    always @(posedge clk) begin
        if (bus1.sr_load) begin
            sh1  <= bus1.sr_din;
            cnt1 <= '0;
        end else begin
            sh1  <= {sh1[WIDTH-2:0], 1'b0};
            if (cnt1 != 4'(WIDTH - 1)) cnt1 <= cnt1 + 4'd1;
        end
        if (bus0.sr_load) begin
            sh0  <= bus0.sr_din;
            cnt0 <= '0;
        end else begin
            sh0  <= {sh0[WIDTH-2:0], 1'b0};
            if (cnt0 != 4'(WIDTH - 1)) cnt0 <= cnt0 + 4'd1;
        end
    end

    assign bus1.sr_done = (cnt1 == 4'(WIDTH - 1)) && !done_kill;
    assign bus0.sr_done = (cnt0 == 4'(WIDTH - 1));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model state: the last granted frame and when the next arbitration may happen
    int               load_cyc;
    int               next_ap;
    int               m_last;
    int               m_chan;
    logic [WIDTH-1:0] m_word;
    logic [WIDTH-1:0] data1 [NREQ];
    int               dq_ch[$];
    int               dq_cy[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive1(input logic en, input logic [NREQ-1:0] req);
        bus1.en  = en;
        bus1.req = req;
        for (int i = 0; i < NREQ; i++) bus1.req_data[i*WIDTH +: WIDTH] = data1[i];
    endtask

    function automatic int rr(input logic [NREQ-1:0] r, input int last);
        int pick;
        bit found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && r[CW'((last + k) % NREQ)]) begin
                pick  = (last + k) % NREQ;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    task automatic model_reset();
        load_cyc = -1000;
        next_ap  = cyc;
        m_last   = NREQ - 1;
        m_chan   = 0;
        m_word   = '0;
        dq_ch.delete();
        dq_cy.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive1(1'b1, '0);
        bus0.en = 1'b1;
        bus0.req = '0;
        bus0.req_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: check outputs against the model, then let the model arbitrate on these inputs.
    task automatic step(input logic en, input logic [NREQ-1:0] req);
        logic [NREQ-1:0]  ack_e;
        logic [WIDTH-1:0] din_e;
        logic             load_e, frame_e, sout_e;
        int               w;
        drive1(en, req);
        ack_e  = '0;
        din_e  = '0;
        sout_e = 1'b0;
        if (cyc == load_cyc) begin
            ack_e = NREQ'(1) << m_chan;
            din_e = m_word;
        end
        frame_e = (cyc > load_cyc) && (cyc <= load_cyc + WIDTH);
        load_e  = !((cyc > load_cyc) && (cyc < load_cyc + WIDTH));
        if (frame_e) sout_e = m_word[BW'(load_cyc + WIDTH - cyc)];
        chk("ack",     bus1.ack,          ack_e);
        chk("sr_din",  bus1.sr_din,       din_e);
        chk("sr_load", bus1.sr_load,      load_e);
        chk("frame",   bus1.frame,        frame_e);
        chk("sout",    sh1[WIDTH-1],      sout_e);
        chk("chan",    bus1.chan,         m_chan);
        chk("err",     bus1.err,          1'b0);
        for (int i = 0; i < NREQ; i++) begin
            if (bus1.ack[i]) begin
                dq_ch.push_back(i);
                dq_cy.push_back(cyc);
            end
        end
        if (cyc >= next_ap) begin
            if (en && (req != '0)) begin
                w        = rr(req, m_last);
                m_last   = w;
                m_chan   = w;
                m_word   = data1[w];
                load_cyc = cyc + 1;
                next_ap  = cyc + WIDTH + GAP;
            end else begin
                next_ap  = cyc + 1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    vec_t             tv [11];
    logic [WIDTH-1:0] a5;
    logic [NREQ-1:0]  rq;
    logic             ren;
    bit               seen;
    int               a0[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) data1[i] = '0;
        drive1(1'b0, '0);
        bus0.en = 1'b0;
        bus0.req = '0;
        bus0.req_data = '0;

        // idle after reset
        do_reset();
        repeat (20) step(1'b1, '0);

        // single request on channel 1, vector table
        do_reset();
        data1[1] = 8'hA5;
        a5 = 8'hA5;
        for (int i = 0; i < 11; i++) begin
            tv[i].en = 1'b1; tv[i].req = '0; tv[i].ack = '0; tv[i].load = 1'b1;
            tv[i].din = '0; tv[i].frame = 1'b0; tv[i].sout = 1'b0; tv[i].chan = CW'(1);
        end
        tv[0].req  = 4'b0010;
        tv[0].chan = CW'(0);
        tv[1].ack  = 4'b0010;
        tv[1].din  = a5;
        for (int i = 2; i <= 9; i++) begin
            tv[i].frame = 1'b1;
            tv[i].sout  = a5[BW'(9 - i)];
            tv[i].load  = (i == 9);
        end
        for (int i = 0; i < 11; i++) begin
            drive1(tv[i].en, tv[i].req);
            chk("t2_ack",     bus1.ack,     tv[i].ack);
            chk("t2_sr_load", bus1.sr_load, tv[i].load);
            chk("t2_sr_din",  bus1.sr_din,  tv[i].din);
            chk("t2_frame",   bus1.frame,   tv[i].frame);
            chk("t2_sout",    sh1[WIDTH-1], tv[i].sout);
            chk("t2_chan",    bus1.chan,    tv[i].chan);
            cyc++;
            @(negedge clk);
        end

        // all requesters held: strict rotation, LOAD every WIDTH+GAP cycles
        do_reset();
        data1[0] = 8'h11; data1[1] = 8'h82; data1[2] = 8'h3C; data1[3] = 8'hE7;
        repeat (46) step(1'b1, 4'b1111);
        chk("t3_grants", dq_ch.size(), 5);
        if (dq_ch.size() == 5) begin
            for (int k = 0; k < 5; k++) chk("t3_chan_seq", dq_ch[k], k % NREQ);
            for (int k = 1; k < 5; k++) chk("t3_period", dq_cy[k] - dq_cy[k-1], WIDTH + GAP);
        end

        // reset mid-frame at bitcnt 3
        do_reset();
        data1[0] = 8'hFF;
        step(1'b1, 4'b0001);
        repeat (4) step(1'b1, '0);
        chk("t5_frame_pre", bus1.frame, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_frame_rst", bus1.frame,   1'b0);
        chk("t5_ack_rst",   bus1.ack,     4'b0000);
        chk("t5_load_rst",  bus1.sr_load, 1'b1);
        chk("t5_din_rst",   bus1.sr_din,  8'h00);
        chk("t5_chan_rst",  bus1.chan,    2'd0);
        @(negedge clk);
        chk("t5_sout_rst",  sh1[WIDTH-1], 1'b0);
        rst = 1'b0;
        model_reset();
        step(1'b1, 4'b0001);
        repeat (12) step(1'b1, '0);
        chk("t5_regrants", dq_ch.size(), 1);
        if (dq_ch.size() == 1) chk("t5_regrant_chan", dq_ch[0], 0);

        // en low: frame in flight completes, no new grant until en returns
        do_reset();
        data1[2] = 8'h3C;
        step(1'b1, 4'b0100);
        repeat (20) step(1'b0, 4'b0100);
        chk("t6_acks_en0", dq_ch.size(), 1);
        step(1'b1, 4'b0100);
        chk("t6_ack_after_en", bus1.ack, 4'b0100);
        repeat (10) step(1'b1, '0);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 3) == 0) data1[i] = WIDTH'($urandom);
            rq  = NREQ'($urandom_range(0, 15));
            ren = ($urandom_range(0, 7) != 0);
            step(ren, rq);
        end

        // GAP=0 build: back-to-back frames on a held request
        do_reset();
        bus0.en = 1'b1;
        bus0.req = 4'b0001;
        bus0.req_data = {NREQ{8'hFF}};
        seen = 1'b0;
        a0.delete();
        for (int i = 0; i < 60; i++) begin
            if (bus0.ack != '0) a0.push_back(i);
            if (seen) begin
                chk("t4_frame", bus0.frame,  1'b1);
                chk("t4_sout",  sh0[WIDTH-1], 1'b1);
            end
            if (bus0.frame) seen = 1'b1;
            @(negedge clk);
        end
        chk("t4_seen", seen, 1'b1);
        chk("t4_acks", a0.size(), 8);
        for (int k = 1; k < a0.size(); k++) chk("t4_period", a0[k] - a0[k-1], WIDTH);
        bus0.req = '0;

`ifdef SHIFT_SCHED_DONE_CHECK_EN
        // missing done pulse sets err, which stays until reset
        do_reset();
        chk("t7_err_reset", bus1.err, 1'b0);
        done_kill = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive1(1'b1, (i == 0) ? 4'b0001 : 4'b0000);
            @(negedge clk);
        end
        chk("t7_err_set", bus1.err, 1'b1);
        done_kill = 1'b0;
        repeat (20) @(negedge clk);
        chk("t7_err_sticky", bus1.err, 1'b1);
        rst = 1'b1;
        #1;
        chk("t7_err_clear", bus1.err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
